// File: rtl/path_delay_ao.sv
// path_delay_ao: clocked OR-AND gate in which every input pin passes through its
// own runtime-programmable delay channel (transport or inertial). It also counts
// the pulses that inertial filtering swallows.
module path_delay_ao #(
  parameter int unsigned N_OR    = 2,
  parameter int unsigned N_AND   = 2,
  parameter int unsigned DLY_W   = 4,
  parameter int unsigned DEF_DLY = 1,
  localparam int unsigned NCH    = N_OR + N_AND,
  localparam int unsigned SEL_W  = $clog2(NCH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_OR-1:0]  or_in,
  input  logic [N_AND-1:0] and_in,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [DLY_W-1:0] cfg_dly,
  input  logic             cfg_inertial,
  output logic             out,
  output logic [15:0]      filt_cnt
);

  localparam int unsigned MAX_DLY = (2 ** DLY_W) - 1;
  // q itself captures the value entering the last used stage, so the stored
  // line only needs MAX_DLY-1 stages behind the live pin.
  localparam int unsigned SR_LEN  = (MAX_DLY > 1) ? (MAX_DLY - 1) : 1;
  localparam int unsigned RS_W    = $clog2(NCH + 1);
  localparam int unsigned FC_W    = 16;
  localparam logic [DLY_W-1:0] DLY_RST = DLY_W'(DEF_DLY);
  localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

  logic [NCH-1:0] w_pin;
  logic [NCH-1:0] w_q;
  logic [NCH-1:0] w_rej;

  // Channel order: OR pins first, then AND pins.
  assign w_pin = {and_in, or_in};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DLY_W-1:0]   r_dly;
    logic [DLY_W-1:0]   w_dly_nxt;
    logic               r_mode;
    logic               w_mode_nxt;
    logic               r_q;
    logic               w_q_nxt;
    logic [SR_LEN-1:0]  r_sr;
    logic [SR_LEN-1:0]  w_sr_nxt;
    logic [DLY_W-1:0]   r_cnt;
    logic [DLY_W-1:0]   w_cnt_nxt;
    logic [DLY_W-1:0]   w_cnt_inc;
    logic [MAX_DLY-1:0] w_line;
    logic               w_wr;
    logic               w_rej_c;

    // Channel selected for a config write; out-of-range selects match nothing.
    assign w_wr      = cfg_we && (cfg_sel == SEL_W'(c));
    assign w_cnt_inc = r_cnt + DLY_ONE;

    // Transport line as it stands this edge: live pin at tap 0, stored stages after.
    always_comb begin
      w_line    = '0;
      w_line[0] = w_pin[c];
      for (int k = 1; k < int'(MAX_DLY); k++) begin
        w_line[k] = r_sr[k-1];
      end
    end

    // Next channel state: config write wins over sampling; else transport or inertial step.
    always_comb begin
      w_dly_nxt  = r_dly;
      w_mode_nxt = r_mode;
      w_q_nxt    = r_q;
      w_sr_nxt   = w_line[SR_LEN-1:0];
      w_cnt_nxt  = r_cnt;
      w_rej_c    = 1'b0;
      if (w_wr) begin
        w_dly_nxt  = (cfg_dly == '0) ? DLY_ONE : cfg_dly;
        w_mode_nxt = cfg_inertial;
        w_cnt_nxt  = '0;
        w_sr_nxt   = {SR_LEN{r_q}};
      end else if (!r_mode) begin
        w_q_nxt   = w_line[r_dly - DLY_ONE];
        w_cnt_nxt = '0;
      end else if (w_pin[c] == r_q) begin
        w_cnt_nxt = '0;
        w_rej_c   = (r_cnt != '0);
      end else if (w_cnt_inc == r_dly) begin
        w_q_nxt   = w_pin[c];
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end

    // Channel registers.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_dly  <= DLY_RST;
        r_mode <= 1'b0;
        r_q    <= 1'b0;
        r_sr   <= '0;
        r_cnt  <= '0;
      end else begin
        r_dly  <= w_dly_nxt;
        r_mode <= w_mode_nxt;
        r_q    <= w_q_nxt;
        r_sr   <= w_sr_nxt;
        r_cnt  <= w_cnt_nxt;
      end
    end

    assign w_q[c]   = r_q;
    assign w_rej[c] = w_rej_c;
  end

  logic [RS_W-1:0] w_rej_sum;
  logic [FC_W:0]   w_filt_sum;
  logic [FC_W-1:0] r_filt;

  // Number of channels rejecting a pulse this edge, added with a carry bit for saturation.
  always_comb begin
    w_rej_sum = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      w_rej_sum = w_rej_sum + RS_W'(w_rej[c]);
    end
    w_filt_sum = {1'b0, r_filt} + (FC_W+1)'(w_rej_sum);
  end

  // Saturating rejected-pulse counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= '0;
    end else begin
      r_filt <= w_filt_sum[FC_W] ? '1 : w_filt_sum[FC_W-1:0];
    end
  end

  assign filt_cnt = r_filt;
  assign out      = (|w_q[N_OR-1:0]) | (&w_q[NCH-1:N_OR]);

endmodule

// File: tb/tb_path_delay_ao.sv
// Directed bench for path_delay_ao: reset, book delays, inertial filtering,
// transport pulses, config collisions, out-of-range selects and saturation.
module tb_path_delay_ao;

  logic        clock;
  logic        reset_n;
  logic [1:0]  or_in;
  logic [1:0]  and_in;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [3:0]  cfg_dly;
  logic        cfg_inertial;
  logic        out;
  logic [15:0] filt_cnt;

  logic [1:0]  or5;
  logic [2:0]  and5;
  logic        cfg5_we;
  logic [2:0]  cfg5_sel;
  logic [3:0]  cfg5_dly;
  logic        cfg5_inertial;
  logic        out5;
  logic [15:0] filt5;

  int n_checks = 0;
  int n_errors = 0;

  path_delay_ao u_dut (
    .clock(clock), .reset_n(reset_n), .or_in(or_in), .and_in(and_in),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_dly(cfg_dly),
    .cfg_inertial(cfg_inertial), .out(out), .filt_cnt(filt_cnt)
  );

  // Five-channel instance so that a select value can be out of range.
  path_delay_ao #(.N_OR(2), .N_AND(3)) u_dut5 (
    .clock(clock), .reset_n(reset_n), .or_in(or5), .and_in(and5),
    .cfg_we(cfg5_we), .cfg_sel(cfg5_sel), .cfg_dly(cfg5_dly),
    .cfg_inertial(cfg5_inertial), .out(out5), .filt_cnt(filt5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [3:0] dly, input logic inr);
    cfg_we       = 1'b1;
    cfg_sel      = sel;
    cfg_dly      = dly;
    cfg_inertial = inr;
    tick();
    cfg_we       = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    or_in = 2'b11; and_in = 2'b11;
    cfg_we = 1'b0; cfg_sel = '0; cfg_dly = '0; cfg_inertial = 1'b0;
    or5 = '0; and5 = '0;
    cfg5_we = 1'b0; cfg5_sel = '0; cfg5_dly = '0; cfg5_inertial = 1'b0;

    // Reset with all pins high
    #2;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_filt", 32'(filt_cnt), 32'd0);
    tick();
    chk("rst_held_out", 32'(out), 32'd0);
    reset_n = 1'b1;
    chk("rel_no_edge", 32'(out), 32'd0);
    tick();
    chk("rel_first_edge", 32'(out), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_rst_out", 32'(out), 32'd0);
    or_in = 2'b00; and_in = 2'b00;
    reset_n = 1'b1;
    tick();

    // Book delays: M,N = 15, P,Q = 12, transport
    cfg(2'd0, 4'd15, 1'b0);
    cfg(2'd1, 4'd15, 1'b0);
    cfg(2'd2, 4'd12, 1'b0);
    cfg(2'd3, 4'd12, 1'b0);
    or_in = 2'b01; and_in = 2'b01;
    for (int e = 0; e <= 19; e++) begin
      tick();
      if (e == 13) chk("book_m_pre", 32'(out), 32'd0);
      if (e == 14) chk("book_m_rise", 32'(out), 32'd1);
    end
    or_in = 2'b00; and_in = 2'b11;
    for (int e = 20; e <= 40; e++) begin
      tick();
      chk("book_nogap", 32'(out), 32'd1);
    end
    and_in = 2'b01;
    for (int e = 41; e <= 52; e++) begin
      tick();
      if (e == 51) chk("book_q_pre", 32'(out), 32'd1);
      if (e == 52) chk("book_q_fall", 32'(out), 32'd0);
    end

    // Inertial filter on channel 0, delay 4
    and_in = 2'b00;
    pulse_reset();
    tick();
    cfg(2'd0, 4'd4, 1'b1);
    tick();
    or_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("inr3_out", 32'(out), 32'd0);
    end
    chk("inr3_filt_pre", 32'(filt_cnt), 32'd0);
    or_in = 2'b00;
    tick();
    chk("inr3_out_end", 32'(out), 32'd0);
    chk("inr3_filt", 32'(filt_cnt), 32'd1);
    tick();
    or_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("inr4_out_a", 32'(out), 32'(i == 3));
    end
    or_in = 2'b00;
    for (int i = 4; i < 8; i++) begin
      tick();
      chk("inr4_out_b", 32'(out), 32'(i < 7));
    end
    chk("inr4_filt", 32'(filt_cnt), 32'd1);

    // Transport single-clock pulse on channel 1, delay 6
    cfg(2'd1, 4'd6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      or_in = (i == 0) ? 2'b10 : 2'b00;
      tick();
      chk("tr_pulse", 32'(out), 32'(i == 5));
    end
    chk("tr_filt", 32'(filt_cnt), 32'd1);

    // Two channels reject on the same edge
    cfg(2'd0, 4'd2, 1'b1);
    cfg(2'd1, 4'd2, 1'b1);
    or_in = 2'b11;
    tick();
    chk("dual_filt_pre", 32'(filt_cnt), 32'd1);
    or_in = 2'b00;
    tick();
    chk("dual_filt", 32'(filt_cnt), 32'd3);
    chk("dual_out", 32'(out), 32'd0);

    // Config write colliding with a pin toggle on channel 2
    cfg(2'd2, 4'd5, 1'b0);
    and_in = 2'b10;
    tick();
    chk("col_setup", 32'(out), 32'd0);
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_dly = 4'd0; cfg_inertial = 1'b0;
    and_in = 2'b11;
    tick();
    cfg_we = 1'b0;
    chk("col_edge", 32'(out), 32'd0);
    and_in = 2'b10;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("col_discard", 32'(out), 32'd0);
    end
    and_in = 2'b11;
    tick();
    chk("col_dly1", 32'(out), 32'd1);

    // Out-of-range selects on the five-channel instance
    and5 = 3'b111;
    tick();
    chk("oor_setup", 32'(out5), 32'd1);
    for (int s = 5; s < 8; s++) begin
      cfg5_we = 1'b1; cfg5_sel = 3'(s); cfg5_dly = 4'd9; cfg5_inertial = 1'b1;
      tick();
    end
    cfg5_we = 1'b0;
    and5 = 3'b110; tick(); chk("oor_ch2", 32'(out5), 32'd0);
    and5 = 3'b111; tick(); chk("oor_ch2_back", 32'(out5), 32'd1);
    and5 = 3'b101; tick(); chk("oor_ch3", 32'(out5), 32'd0);
    and5 = 3'b111; tick(); chk("oor_ch3_back", 32'(out5), 32'd1);
    and5 = 3'b011; tick(); chk("oor_ch4", 32'(out5), 32'd0);
    and5 = 3'b000;
    or5 = 2'b10; tick(); chk("oor_ch1", 32'(out5), 32'd1);
    or5 = 2'b00; tick(); chk("oor_ch1_back", 32'(out5), 32'd0);
    or5 = 2'b01; tick(); chk("oor_ch0", 32'(out5), 32'd1);
    or5 = 2'b00; tick(); chk("oor_ch0_back", 32'(out5), 32'd0);
    chk("oor_filt", 32'(filt5), 32'd0);

    // Saturation: four inertial channels reject every other edge
    or_in = 2'b00; and_in = 2'b00;
    pulse_reset();
    tick();
    for (int c = 0; c < 4; c++) cfg(2'(c), 4'd2, 1'b1);
    chk("sat_start", 32'(filt_cnt), 32'd0);
    for (int p = 0; p < 16400; p++) begin
      or_in = 2'b11; and_in = 2'b11;
      tick();
      or_in = 2'b00; and_in = 2'b00;
      tick();
      if (p == 99) begin
        chk("sat_400", 32'(filt_cnt), 32'd400);
        chk("sat_out", 32'(out), 32'd0);
      end
      if (p == 16382) chk("sat_fffc", 32'(filt_cnt), 32'hFFFC);
      if (p == 16383) chk("sat_hit", 32'(filt_cnt), 32'hFFFF);
    end
    chk("sat_hold", 32'(filt_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
